// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared constants and helpers for the TMDS channel encoder
//
// Contents:
//   TOKEN_C00..TOKEN_C11  control-period symbols for {c1,c0}
//   CNT_W                 width of the signed running-disparity counter
//   popcount8()           number of ones in an 8-bit value
//   ctrl_token()          control symbol for a given {c1,c0}
package tmds_pkg;

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  localparam int CNT_W = 5;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      p = p + 4'(v[i]);
    end
    return p;
  endfunction

  function automatic logic [9:0] ctrl_token(input logic [1:0] cc);
    logic [9:0] t;
    case (cc)
      2'b00:   t = TOKEN_C00;
      2'b01:   t = TOKEN_C01;
      2'b10:   t = TOKEN_C10;
      default: t = TOKEN_C11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_encoder.sv
// rtl/tmds_encoder.sv - one DVI TMDS channel: 8b/10b transition-minimised, DC-balanced symbols
//
// Ports:
//   clk_pixel  in   pixel clock, the only clock
//   rst_n      in   asynchronous active-low reset
//   data       in   C_depth-bit colour value (active video only)
//   c          in   control bits {c1,c0} (control period only)
//   blank      in   1 = control period, 0 = active video
//   encoded    out  10-bit TMDS symbol, bit 0 transmitted first
//
// Build option: TMDS_ENCODER_OUTREG_EN adds a register after stage 2
// (latency 3 instead of 2); reset value of encoded is the same either way.
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int C_depth = 8
) (
  input  logic               clk_pixel,
  input  logic               rst_n,
  input  logic [C_depth-1:0] data,
  input  logic [1:0]         c,
  input  logic               blank,
  output logic [9:0]         encoded
);

  // Replicate the narrow value MSB-first so full scale maps to 0xFF.
  function automatic logic [7:0] widen(input logic [C_depth-1:0] v);
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      w[7-i] = v[C_depth-1-(i%C_depth)];
    end
    return w;
  endfunction

  // Chain XOR/XNOR through the byte; bit 8 records which operator was used.
  function automatic logic [8:0] minimise(input logic [7:0] d, input logic use_xnor);
    logic [8:0] q;
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  // ---------------- stage 1: transition minimisation ----------------
  logic [7:0] d_wide;
  logic [3:0] n1_d;
  logic       use_xnor;
  logic [8:0] qm;

  always_comb begin
    d_wide   = widen(data);
    n1_d     = popcount8(d_wide);
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d_wide[0]);
    qm       = minimise(d_wide, use_xnor);
  end

  logic [8:0] qm_r;
  logic       blank_r;
  logic [1:0] c_r;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      qm_r    <= '0;
      blank_r <= 1'b1;
      c_r     <= 2'b00;
    end else begin
      qm_r    <= qm;
      blank_r <= blank;
      c_r     <= c;
    end
  end

  // ---------------- stage 2: DC balance ----------------
  // All disparity arithmetic is modulo 2^CNT_W; every intermediate result
  // that is kept lies inside the signed range, so the wrap is exact.
  logic [3:0]              n1_q;
  logic signed [CNT_W-1:0] diff;      // n1 - n0 of qm_r[7:0]
  logic                    cnt_pos;
  logic                    cnt_neg;
  logic                    q8;
  logic [9:0]              enc_nxt;
  logic signed [CNT_W-1:0] cnt_nxt;
  logic signed [CNT_W-1:0] cnt_r;
  logic [9:0]              enc_r;

  always_comb begin
    n1_q    = popcount8(qm_r[7:0]);
    diff    = signed'({n1_q, 1'b0} - 5'd8);
    cnt_neg = cnt_r[CNT_W-1];
    cnt_pos = !cnt_r[CNT_W-1] && (cnt_r != '0);
    q8      = qm_r[8];
    enc_nxt = ctrl_token(c_r);
    cnt_nxt = '0;
    if (blank_r) begin
      enc_nxt = ctrl_token(c_r);
      cnt_nxt = '0;
    end else if ((cnt_r == '0) || (n1_q == 4'd4)) begin
      enc_nxt = {~q8, q8, q8 ? qm_r[7:0] : ~qm_r[7:0]};
      cnt_nxt = q8 ? (cnt_r + diff) : (cnt_r - diff);
    end else if ((cnt_pos && (n1_q > 4'd4)) || (cnt_neg && (n1_q < 4'd4))) begin
      enc_nxt = {1'b1, q8, ~qm_r[7:0]};
      cnt_nxt = cnt_r + (q8 ? 5'sd2 : 5'sd0) - diff;
    end else begin
      enc_nxt = {1'b0, q8, qm_r[7:0]};
      cnt_nxt = cnt_r + diff - (q8 ? 5'sd0 : 5'sd2);
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      enc_r <= TOKEN_C00;
      cnt_r <= '0;
    end else begin
      enc_r <= enc_nxt;
      cnt_r <= cnt_nxt;
    end
  end

`ifdef TMDS_ENCODER_OUTREG_EN
  // Retime so the serializer loads straight from a flop.
  logic [9:0] out_r;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      out_r <= TOKEN_C00;
    end else begin
      out_r <= enc_r;
    end
  end

  assign encoded = out_r;
`else
  assign encoded = enc_r;
`endif

endmodule

// File: tb/tb_tmds_encoder.sv
// tb/tb_tmds_encoder.sv - directed and soak bench for tmds_encoder (C_depth 8 and 3 instances)
module tb_tmds_encoder;

`ifdef TMDS_ENCODER_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  localparam logic [9:0] T00 = 10'h354;

  logic       clk_pixel = 1'b0;
  logic       rst_n;
  logic [7:0] data8;
  logic [2:0] data3;
  logic [1:0] c;
  logic       blank;
  logic [9:0] enc8;
  logic [9:0] enc3;

  always #5 clk_pixel = ~clk_pixel;

  tmds_encoder #(.C_depth(8)) dut8 (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .data      (data8),
    .c         (c),
    .blank     (blank),
    .encoded   (enc8)
  );

  tmds_encoder #(.C_depth(3)) dut3 (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .data      (data3),
    .c         (c),
    .blank     (blank),
    .encoded   (enc3)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cnt8    = 0;
  int cnt3    = 0;
  logic [9:0] q8[$];
  logic [9:0] q3[$];

  typedef struct {
    logic       blank;
    logic [1:0] c;
    logic [7:0] d;
    logic [9:0] expect_sym;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp_v);
  endtask

  function automatic logic [7:0] widen3(input logic [2:0] v);
    return {v, v, v[2:1]};
  endfunction

  // Reference encoder written from the algorithm description with plain ints.
  task automatic model(input logic b, input logic [1:0] cc, input logic [7:0] d,
                       inout int cnt, output logic [9:0] sym);
    logic [8:0] q;
    int ones_d, ones_q, df;
    bit xn;
    if (b) begin
      case (cc)
        2'b00: sym = 10'b1101010100;
        2'b01: sym = 10'b0010101011;
        2'b10: sym = 10'b0101010100;
        default: sym = 10'b1010101011;
      endcase
      cnt = 0;
    end else begin
      ones_d = $countones(d);
      xn = (ones_d > 4) || (ones_d == 4 && d[0] == 1'b0);
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = xn ? !(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      q[8] = !xn;
      ones_q = $countones(q[7:0]);
      df = ones_q - (8 - ones_q);
      if (cnt == 0 || df == 0) begin
        sym = {!q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
        cnt = cnt + (q[8] ? df : -df);
      end else if ((cnt > 0 && df > 0) || (cnt < 0 && df < 0)) begin
        sym = {1'b1, q[8], ~q[7:0]};
        cnt = cnt + (q[8] ? 2 : 0) - df;
      end else begin
        sym = {1'b0, q[8], q[7:0]};
        cnt = cnt + df - (q[8] ? 0 : 2);
      end
    end
  endtask

  // Apply one input set to both instances and check the symbol that is now due.
  task automatic cycle(input logic b, input logic [1:0] cc, input logic [7:0] d8,
                       input logic [2:0] d3, input logic [9:0] e8, input logic [9:0] e3,
                       input string tag);
    blank = b;
    c     = cc;
    data8 = d8;
    data3 = d3;
    q8.push_back(e8);
    q3.push_back(e3);
    @(posedge clk_pixel);
    #1;
    check({tag, "_d8"}, enc8, q8.pop_front());
    check({tag, "_d3"}, enc3, q3.pop_front());
  endtask

  // The pipeline holds reset-token symbols right after reset release.
  task automatic restart_model();
    q8.delete();
    q3.delete();
    for (int i = 0; i < LAT - 1; i++) begin
      q8.push_back(T00);
      q3.push_back(T00);
    end
    cnt8 = 0;
    cnt3 = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0] m8, m3;
    logic [7:0] r8;
    logic [2:0] r3;
    logic       rb;
    logic [1:0] rc;

    tbl[0]  = '{1'b1, 2'b00, 8'h00, 10'h354};
    tbl[1]  = '{1'b1, 2'b01, 8'h00, 10'h0AB};
    tbl[2]  = '{1'b1, 2'b10, 8'h00, 10'h154};
    tbl[3]  = '{1'b1, 2'b11, 8'h00, 10'h2AB};
    tbl[4]  = '{1'b0, 2'b00, 8'h00, 10'h100};
    tbl[5]  = '{1'b0, 2'b00, 8'h00, 10'h3FF};
    tbl[6]  = '{1'b1, 2'b00, 8'h00, 10'h354};
    tbl[7]  = '{1'b0, 2'b00, 8'hFF, 10'h200};
    tbl[8]  = '{1'b1, 2'b00, 8'h00, 10'h354};
    tbl[9]  = '{1'b0, 2'b00, 8'hFF, 10'h200};
    tbl[10] = '{1'b0, 2'b00, 8'hFF, 10'h0FF};
    tbl[11] = '{1'b0, 2'b00, 8'hFF, 10'h0FF};
    tbl[12] = '{1'b0, 2'b00, 8'hFF, 10'h200};
    tbl[13] = '{1'b0, 2'b00, 8'hFF, 10'h0FF};
    tbl[14] = '{1'b0, 2'b00, 8'hFF, 10'h200};
    tbl[15] = '{1'b0, 2'b00, 8'hFF, 10'h0FF};
    tbl[16] = '{1'b0, 2'b00, 8'hFF, 10'h200};
    tbl[17] = '{1'b1, 2'b00, 8'h00, 10'h354};

    // Reset held with random inputs: output pinned to the c=00 token.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data8 = 8'($urandom);
      data3 = 3'($urandom);
      c     = 2'($urandom);
      blank = 1'($urandom);
      @(posedge clk_pixel);
      #1;
      check("reset_d8", enc8, T00);
      check("reset_d3", enc3, T00);
    end

    // Release in a control period: token 00 persists.
    blank = 1'b1;
    c     = 2'b00;
    rst_n = 1'b1;
    restart_model();
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'b00, 8'h00, 3'b000, T00, T00, "post_reset");

    // Directed table; model kept in step so the soak starts from a known cnt.
    for (int i = 0; i < 18; i++) begin
      model(tbl[i].blank, tbl[i].c, tbl[i].d, cnt8, m8);
      model(tbl[i].blank, tbl[i].c, widen3(tbl[i].d[7:5]), cnt3, m3);
      cycle(tbl[i].blank, tbl[i].c, tbl[i].d, tbl[i].d[7:5],
            tbl[i].expect_sym, tbl[i].expect_sym, $sformatf("tbl%0d", i));
    end

    // Soak: random active pixels with a short blanking burst every 800.
    for (int i = 0; i < 10000; i++) begin
      rb = (i % 800) < 16;
      rc = 2'($urandom);
      r8 = 8'($urandom);
      r3 = 3'($urandom);
      model(rb, rc, r8, cnt8, m8);
      model(rb, rc, widen3(r3), cnt3, m3);
      cycle(rb, rc, r8, r3, m8, m3, "soak");
    end

    // Asynchronous reset mid-line, away from the clock edge.
    @(posedge clk_pixel);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_d8", enc8, T00);
    check("async_reset_d3", enc3, T00);
    @(posedge clk_pixel);
    #1;
    blank = 1'b0;
    data8 = 8'hFF;
    data3 = 3'b111;
    rst_n = 1'b1;
    restart_model();

    // First active symbols after reset start from cnt=0.
    cycle(1'b0, 2'b00, 8'hFF, 3'b111, 10'h200, 10'h200, "after_reset0");
    cycle(1'b0, 2'b00, 8'hFF, 3'b111, 10'h0FF, 10'h0FF, "after_reset1");
    for (int i = 0; i < LAT; i++) cycle(1'b1, 2'b01, 8'h00, 3'b000, 10'h0AB, 10'h0AB, "drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
